// File: rtl/instr_fetch_if.sv
// Fetch-stage bus: ROM address/data on one side, valid/ready word stream and
// PC redirect on the other. The master modport belongs to the fetch stage.
interface instr_fetch_if #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 16
);
  logic [ADDR_WIDTH-1:0] o_rom_addr;
  logic [DATA_WIDTH-1:0] i_rom_data;
  logic                  i_redirect;
  logic [ADDR_WIDTH-1:0] i_redirect_pc;
  logic                  o_valid;
  logic                  i_ready;
  logic [DATA_WIDTH-1:0] o_instr;
  logic [ADDR_WIDTH-1:0] o_pc;

  modport master (
    output o_rom_addr, o_valid, o_instr, o_pc,
    input  i_rom_data, i_redirect, i_redirect_pc, i_ready
  );

  modport slave (
    input  o_rom_addr, o_valid, o_instr, o_pc,
    output i_rom_data, i_redirect, i_redirect_pc, i_ready
  );
endinterface

// File: rtl/instr_fetch.sv
// Instruction fetch: issues ROM reads, absorbs the 1-cycle ROM latency and
// buffers {pc, instr} in a 2-entry head/tail FIFO toward decode.
module instr_fetch #(
  parameter int                    ADDR_WIDTH = 10,
  parameter int                    DATA_WIDTH = 16,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  instr_fetch_if.master bus
);

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] pc;
    logic [DATA_WIDTH-1:0] instr;
  } entry_t;

  localparam logic [ADDR_WIDTH-1:0] PC_STEP = ADDR_WIDTH'(1);

  logic [ADDR_WIDTH-1:0] fetch_pc, inflight_pc;
  logic                  inflight;
  logic [1:0]            count;
  entry_t                head, tail, land;
  logic                  pop, push, issue;
  logic [2:0]            occ;

  assign bus.o_rom_addr = bus.i_redirect ? bus.i_redirect_pc : fetch_pc;

  assign pop   = (count != 2'd0) & bus.i_ready & ~bus.i_redirect;
  assign push  = inflight & ~bus.i_redirect;
  // Occupancy after this cycle's pop plus the word still in the ROM pipe;
  // only issue when that word is guaranteed a free slot.
  assign occ   = {1'b0, count} - {2'b0, pop} + {2'b0, inflight};
  assign issue = bus.i_redirect | (occ < 3'd2);
  assign land  = '{pc: inflight_pc, instr: bus.i_rom_data};

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      fetch_pc    <= RESET_PC;
      inflight    <= 1'b0;
      inflight_pc <= '0;
      count       <= 2'd0;
      head        <= '0;
      tail        <= '0;
    end else begin
      inflight <= issue;
      if (issue) begin
        inflight_pc <= bus.o_rom_addr;
        fetch_pc    <= bus.o_rom_addr + PC_STEP;
      end

      if (bus.i_redirect) count <= 2'd0;
      else                count <= count + {1'b0, push} - {1'b0, pop};

      // Head stays put when the FIFO drains so o_pc/o_instr hold their last value.
      if (pop) begin
        if (count == 2'd2)  head <= tail;
        else if (push)      head <= land;
        if (count == 2'd2 && push) tail <= land;
      end else if (push) begin
        if (count == 2'd0)  head <= land;
        else                tail <= land;
      end
    end
  end

  assign bus.o_valid = (count != 2'd0);
  assign bus.o_instr = head.instr;
  assign bus.o_pc    = head.pc;

endmodule

// File: tb/tb_instr_fetch.sv
// Scoreboarded bench for instr_fetch: ROM model mem[i]=0x100+i, expected PC
// stream loaded at reset/redirect and consumed on every accepted handshake.
module tb_instr_fetch;
  localparam int AW = 10;
  localparam int DW = 16;

  logic gclk = 1'b0;
  logic grst_n;
  always #5 gclk = ~gclk;

  instr_fetch_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  instr_fetch #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RESET_PC('0)) dut (
    .i_clk   (gclk),
    .i_rst_n (grst_n),
    .bus     (bus.master)
  );

  // Synchronous ROM, one-cycle read latency.
  always @(posedge gclk) bus.i_rom_data <= 16'h0100 + {6'b0, bus.o_rom_addr};

  int n_vec = 0;
  int n_err = 0;
  logic [AW-1:0] sb[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic sb_load(input logic [AW-1:0] start);
    sb.delete();
    for (int i = 0; i < 512; i++) sb.push_back(start + AW'(i));
  endtask

  task automatic step();
    @(posedge gclk);
    #1;
  endtask

  // Accepted handshake is decided at the coming edge; inputs are stable by negedge.
  always @(negedge gclk) begin
    if (grst_n && bus.o_valid && bus.i_ready && !bus.i_redirect) begin
      if (sb.size() == 0) chk("sb_underrun", 32'(bus.o_pc), 32'hFFFF);
      else begin
        logic [AW-1:0] exp_pc;
        exp_pc = sb.pop_front();
        chk("sb_pc", 32'(bus.o_pc), 32'(exp_pc));
        chk("sb_instr", 32'(bus.o_instr), 32'(16'h0100 + {6'b0, exp_pc}));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running want finished");
    $fatal(1, "timeout");
  end

  initial begin
    bit found;
    logic [AW-1:0] pc_before;
    grst_n            = 1'b0;
    bus.i_ready       = 1'b1;
    bus.i_redirect    = 1'b0;
    bus.i_redirect_pc = '0;
    sb_load('0);
    repeat (3) @(posedge gclk);
    #2;
    chk("rst_valid", 32'(bus.o_valid), 0);
    chk("rst_pc", 32'(bus.o_pc), 0);
    chk("rst_instr", 32'(bus.o_instr), 0);
    chk("rst_addr", 32'(bus.o_rom_addr), 0);

    @(negedge gclk) grst_n = 1'b1;
    step();
    chk("lat_c1_valid", 32'(bus.o_valid), 0);
    step();
    chk("lat_c2_valid", 32'(bus.o_valid), 1);
    chk("lat_c2_pc", 32'(bus.o_pc), 0);

    // Stall while o_pc=3.
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (bus.o_valid && bus.o_pc == 10'd3) found = 1'b1;
      else step();
    end
    chk("find_pc3", 32'(found), 1);
    bus.i_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("stall_pc", 32'(bus.o_pc), 3);
      chk("stall_instr", 32'(bus.o_instr), 32'h103);
      chk("stall_addr", 32'(bus.o_rom_addr), 5);
      step();
    end
    bus.i_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      chk("resume_valid", 32'(bus.o_valid), 1);
      step();
    end

    // Full FIFO, then redirect with ready high (pop must be cancelled).
    bus.i_ready = 1'b0;
    repeat (3) step();
    pc_before = bus.o_pc;
    bus.i_redirect = 1'b1; bus.i_redirect_pc = 10'h200; bus.i_ready = 1'b1;
    sb_load(10'h200);
    step();
    bus.i_redirect = 1'b0;
    chk("redir_n1_valid", 32'(bus.o_valid), 0);
    chk("redir_n1_hold", 32'(bus.o_pc), 32'(pc_before));
    step();
    chk("redir_n2_valid", 32'(bus.o_valid), 1);
    chk("redir_n2_pc", 32'(bus.o_pc), 32'h200);
    chk("redir_n2_instr", 32'(bus.o_instr), 32'h300);
    repeat (4) step();

    // Wrap at the top of the address space.
    bus.i_redirect = 1'b1; bus.i_redirect_pc = 10'h3FE;
    sb_load(10'h3FE);
    step();
    bus.i_redirect = 1'b0;
    step();
    chk("wrap_pc0", 32'(bus.o_pc), 32'h3FE);
    repeat (5) step();

    // Back-to-back redirects: the second target wins.
    bus.i_redirect = 1'b1; bus.i_redirect_pc = 10'h050;
    sb_load(10'h050);
    step();
    bus.i_redirect_pc = 10'h080;
    sb_load(10'h080);
    step();
    bus.i_redirect = 1'b0;
    chk("b2b_n1_valid", 32'(bus.o_valid), 0);
    step();
    chk("b2b_n2_valid", 32'(bus.o_valid), 1);
    chk("b2b_n2_pc", 32'(bus.o_pc), 32'h080);

    // Random backpressure with one redirect in the middle.
    for (int i = 0; i < 200; i++) begin
      bus.i_ready    = 1'($urandom_range(0, 1));
      bus.i_redirect = (i == 100);
      bus.i_redirect_pc = 10'h123;
      if (i == 100) sb_load(10'h123);
      step();
    end
    bus.i_redirect = 1'b0;
    bus.i_ready    = 1'b1;
    repeat (4) step();

    // Asynchronous reset between edges.
    #2 grst_n = 1'b0;
    #1;
    chk("arst_valid", 32'(bus.o_valid), 0);
    chk("arst_pc", 32'(bus.o_pc), 0);
    chk("arst_instr", 32'(bus.o_instr), 0);
    chk("arst_addr", 32'(bus.o_rom_addr), 0);
    sb_load('0);
    @(negedge gclk) grst_n = 1'b1;
    step();
    chk("rerst_c1_valid", 32'(bus.o_valid), 0);
    step();
    chk("rerst_c2_valid", 32'(bus.o_valid), 1);
    chk("rerst_c2_pc", 32'(bus.o_pc), 0);
    repeat (6) step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
